// File: rtl/difftest_endpoint_pkg.sv
// Purpose: shared FSM states, result codes and exit constants for the difftest endpoint monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package difftest_endpoint_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DONE    = 3'd1,
    ST_ABORT   = 3'd2,
    ST_STUCK   = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam logic [2:0] RES_RUN     = 3'd0;
  localparam logic [2:0] RES_DONE    = 3'd1;
  localparam logic [2:0] RES_ABORT   = 3'd2;
  localparam logic [2:0] RES_STUCK   = 3'd3;
  localparam logic [2:0] RES_TIMEOUT = 3'd4;

  localparam logic [63:0] EXIT_GOOD = 64'hffff_ffff_ffff_ffff;

  // Map an FSM state onto the externally visible result code.
  function automatic logic [2:0] state_to_result(input state_e s);
    logic [2:0] r;
    case (s)
      ST_DONE:    r = RES_DONE;
      ST_ABORT:   r = RES_ABORT;
      ST_STUCK:   r = RES_STUCK;
      ST_TIMEOUT: r = RES_TIMEOUT;
      default:    r = RES_RUN;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/difftest_stuck_watchdog.sv
// Purpose: one core's no-progress timer (saturating) compared against the stuck threshold.
// Latency: stuck is combinational on this cycle's step (uses the next timer value).
// Backpressure: none; pure observer.
module difftest_stuck_watchdog #(
  parameter int STEP_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [63:0]           stuck_limit,
  input  logic                  excluded,
  output logic                  stuck
);

  logic [63:0] timer_q;
  logic [63:0] timer_d;

  // Clear on progress, otherwise count up and hold at all-ones.
  always_comb begin
    timer_d = timer_q;
    if (step != '0) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 64'd1;
    end
  end

  // Timer register.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Comparing the next value lets a stall seen this cycle act at this edge.
  assign stuck = !excluded && (stuck_limit != 64'd0) && (timer_d >= stuck_limit);

endmodule

// File: rtl/difftest_endpoint_monitor.sv
// Purpose: N-core simulation-end monitor: stuck/timeout/exit aggregation into a sticky result, perf pulses.
// Latency: all outputs registered, inputs at edge t visible after edge t+1. Optional DIFFTEST_MON_INSTR_LIMIT_EN.
// Backpressure: none; perf_clean requests arriving during an active pulse are dropped.
module difftest_endpoint_monitor
  import difftest_endpoint_pkg::*;
#(
  parameter  int NUM_CORES    = 2,
  parameter  int STEP_WIDTH   = 8,
  parameter  int CLEAN_CYCLES = 2,
  localparam int FCW          = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES*STEP_WIDTH-1:0] difftest_step,
  input  logic [NUM_CORES*64-1:0]         difftest_exit,
  input  logic [63:0]                     stuck_limit,
  input  logic [63:0]                     max_cycles,
`ifdef DIFFTEST_MON_INSTR_LIMIT_EN
  input  logic [63:0]                     max_instrs,
  output logic [NUM_CORES*64-1:0]         instr_count,
`endif
  input  logic                            perf_clean_req,
  output logic                            perf_clean,
  output logic                            perf_dump,
  output logic                            finish,
  output logic [2:0]                      result,
  output logic [FCW-1:0]                  fail_core,
  output logic [63:0]                     exit_code,
  output logic [NUM_CORES-1:0]            stuck_mask,
  output logic [63:0]                     n_cycles
);

  localparam int CW = $clog2(CLEAN_CYCLES + 1);

  state_e               state_q;
  state_e               state_d;
  logic [NUM_CORES-1:0] good_q;
  logic [NUM_CORES-1:0] good_now;
  logic [NUM_CORES-1:0] bad_now;
  logic [NUM_CORES-1:0] stuck_now;
  logic [FCW-1:0]       bad_idx;
  logic [FCW-1:0]       stuck_idx;
  logic [63:0]          bad_exit;
  logic                 bad_found;
  logic                 stuck_found;
  logic [CW-1:0]        clean_cnt_q;
  logic [CW-1:0]        clean_cnt_d;

  // Per-core exit classification and stuck watchdog.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    logic [63:0] exit_i;
    assign exit_i      = difftest_exit[i*64 +: 64];
    assign good_now[i] = (exit_i == EXIT_GOOD);
    assign bad_now[i]  = (exit_i != 64'd0) && (exit_i != EXIT_GOOD);

    difftest_stuck_watchdog #(
      .STEP_WIDTH (STEP_WIDTH)
    ) u_watchdog (
      .clock       (clock),
      .reset       (reset),
      .step        (difftest_step[i*STEP_WIDTH +: STEP_WIDTH]),
      .stuck_limit (stuck_limit),
      .excluded    (good_q[i] | good_now[i]),
      .stuck       (stuck_now[i])
    );
  end

`ifdef DIFFTEST_MON_INSTR_LIMIT_EN
  logic [NUM_CORES-1:0] instr_hit;

  // Per-core committed-instruction totals, frozen once the run ends.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_instr
    logic [63:0] icount_q;

    // Accumulate zero-extended steps only while running.
    always_ff @(posedge clock) begin
      if (reset) begin
        icount_q <= '0;
      end else if (state_q == ST_RUN) begin
        icount_q <= icount_q + 64'(difftest_step[i*STEP_WIDTH +: STEP_WIDTH]);
      end
    end

    assign instr_count[i*64 +: 64] = icount_q;
    assign instr_hit[i] = (max_instrs != 64'd0) && (icount_q >= max_instrs);
  end
`endif

  // Lowest-index bad core (with its exit value) and lowest-index stuck core.
  always_comb begin
    bad_idx     = '0;
    bad_exit    = '0;
    bad_found   = 1'b0;
    stuck_idx   = '0;
    stuck_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (bad_now[i] && !bad_found) begin
        bad_found = 1'b1;
        bad_idx   = FCW'(i);
        bad_exit  = difftest_exit[i*64 +: 64];
      end
      if (stuck_now[i] && !stuck_found) begin
        stuck_found = 1'b1;
        stuck_idx   = FCW'(i);
      end
    end
  end

  // Next-state: leave RUN by priority; terminal states hold until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (bad_found) begin
        state_d = ST_ABORT;
      end else if (stuck_found) begin
        state_d = ST_STUCK;
      end else if ((max_cycles != 64'd0) && (n_cycles >= max_cycles)) begin
        state_d = ST_TIMEOUT;
      end
`ifdef DIFFTEST_MON_INSTR_LIMIT_EN
      else if (|instr_hit) begin
        state_d = ST_DONE;
      end
`endif
      else if (&(good_q | good_now)) begin
        state_d = ST_DONE;
      end
    end
  end

  // State, result and bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      result     <= RES_RUN;
      finish     <= 1'b0;
      perf_dump  <= 1'b0;
      fail_core  <= '0;
      exit_code  <= '0;
      stuck_mask <= '0;
      n_cycles   <= '0;
      good_q     <= '0;
    end else begin
      state_q    <= state_d;
      result     <= state_to_result(state_d);
      finish     <= (state_d != ST_RUN);
      perf_dump  <= (state_q == ST_RUN) && (state_d != ST_RUN);
      stuck_mask <= stuck_now;
      if (state_q == ST_RUN) begin
        good_q <= good_q | good_now;
      end
      // The exit edge is not counted as a RUN cycle.
      if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
        n_cycles <= n_cycles + 64'd1;
      end
      if ((state_q == ST_RUN) && (state_d == ST_ABORT)) begin
        fail_core <= bad_idx;
        exit_code <= bad_exit;
      end
      if ((state_q == ST_RUN) && (state_d == ST_STUCK)) begin
        fail_core <= stuck_idx;
      end
    end
  end

  // perf_clean countdown: a request from idle loads the full pulse length.
  always_comb begin
    clean_cnt_d = '0;
    if (clean_cnt_q != '0) begin
      clean_cnt_d = clean_cnt_q - CW'(1);
    end else if (perf_clean_req) begin
      clean_cnt_d = CW'(CLEAN_CYCLES);
    end
  end

  // perf_clean register; reset cancels any pulse in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      clean_cnt_q <= '0;
      perf_clean  <= 1'b0;
    end else begin
      clean_cnt_q <= clean_cnt_d;
      perf_clean  <= (clean_cnt_d != '0);
    end
  end

endmodule

// File: doc/difftest_endpoint_monitor.md
# difftest_endpoint_monitor

Parametrised, synthesisable simulation-end monitor for an N-core DiffTest top, sitting between the DUT's difftest outputs (step, exit) and the testbench harness. Per-core stuck watchdogs, a global cycle limit, exit-code aggregation and a sticky terminal-state FSM. Generates the perf-clean and perf-dump pulses. Exposes a registered result code that the harness uses to finish or fail the run.

## Interface
Parameters:
- NUM_CORES, 2: number of monitored cores, at least 1.
- STEP_WIDTH, 8: width of each core's step count.
- CLEAN_CYCLES, 2: length of the perf_clean pulse in cycles, at least 1.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- difftest_step  in  NUM_CORES*STEP_WIDTH  per-core committed-step count this cycle; core i is slice [i*STEP_WIDTH +: STEP_WIDTH].
- difftest_exit  in  NUM_CORES*64  per-core exit code. 0 means running, all-ones means good exit, any other value is an error.
- stuck_limit  in  64  stuck threshold in cycles; 0 disables the check.
- max_cycles  in  64  cycle limit; 0 disables the check.
- perf_clean_req  in  1  single-cycle request to clear performance counters.
- perf_clean  out  1  clear pulse to the DUT.
- perf_dump  out  1  one-cycle pulse when a terminal state is entered.
- finish  out  1  high while in a terminal state.
- result  out  3  0 RUN, 1 DONE, 2 ABORT, 3 STUCK, 4 TIMEOUT.
- fail_core  out  $clog2(NUM_CORES) or 1  index of the core that caused ABORT or STUCK.
- exit_code  out  64  exit code latched at ABORT.
- stuck_mask  out  NUM_CORES  per-core live stuck flags.
- n_cycles  out  64  cycles spent in RUN.

## Operation
- The FSM has states RUN, DONE, ABORT, STUCK and TIMEOUT. Reset enters RUN.
- Every terminal state is sticky until reset.
- n_cycles increments by 1 each cycle in RUN and freezes in terminal states.
- Per-core stuck timer:
  - cleared when that core's step is nonzero, otherwise incremented;
  - saturates at all-ones;
  - stuck_mask[i] = (stuck_limit != 0) && (timer_i >= stuck_limit).
- Core i is good when its exit is all-ones; core i is bad when its exit is nonzero and not all-ones.
- Good-exit flags are sticky per core. A core that has exited good is excluded from stuck checking.
- Transitions out of RUN are evaluated on the same-cycle inputs. Priority, highest first:
  1. Any bad core: ABORT. fail_core is the lowest bad index; exit_code is that core's exit value.
  2. Any stuck core: STUCK. fail_core is the lowest stuck index.
  3. max_cycles != 0 && n_cycles >= max_cycles: TIMEOUT.
  4. All cores good, counting flags already set plus this cycle: DONE.
- perf_dump is high for exactly one cycle, the first cycle in which result is nonzero.
- perf_clean:
  - perf_clean_req while idle drives perf_clean high for CLEAN_CYCLES consecutive cycles, starting the next cycle.
  - Requests while the pulse is active are ignored and do not restart or extend it.
  - Requests are honoured in any FSM state.

## Timing
- All outputs are registered. Inputs sampled at edge t are reflected at edge t+1.
- Reset values:
  - result 0, finish 0;
  - perf_clean 0, perf_dump 0;
  - fail_core 0, exit_code 0;
  - stuck_mask 0, n_cycles 0;
  - all timers, flags and counters 0.
- Reset asserted mid-run or in a terminal state returns the block to RUN on the next edge. Any perf_clean pulse in flight is cancelled.
- Changes to stuck_limit and max_cycles take effect in the next comparison; they are not latched.
- Widths: all comparisons are unsigned 64-bit, and STEP_WIDTH is zero-extended.

## Configuration
- DIFFTEST_MON_INSTR_LIMIT_EN defined:
  - adds port max_instrs (in, 64);
  - adds port instr_count (out, NUM_CORES*64), the per-core sums of step with reset value 0, frozen in terminal states;
  - any core with instr_count >= max_instrs != 0 forces DONE, at priority between TIMEOUT and the all-good DONE.
- Undefined: neither port exists and no instruction counters are instantiated.

## Structure
- Package difftest_endpoint_pkg holds:
  - the state enum and result code constants (RES_RUN, RES_DONE, RES_ABORT, RES_STUCK, RES_TIMEOUT);
  - the localparam EXIT_GOOD = 64'hffff_ffff_ffff_ffff.
- Sub-module difftest_stuck_watchdog holds one core's timer, saturation and compare. It is instantiated NUM_CORES times via generate.

## Test plan
- Abort: NUM_CORES=2; core1 exit=0x5 at cycle 10 -> result=2, fail_core=1, exit_code=0x5 at cycle 11; perf_dump high for one cycle; n_cycles=10 frozen.
- Good exit: core0 exits all-ones at cycle 20 and core1 at cycle 30 -> DONE at cycle 31. Core0 gets no step from cycle 20 with stuck_limit=5 -> no STUCK.
- Stuck: stuck_limit=100; core0 steps once at cycle 3 and then never -> STUCK at cycle 104, fail_core=0, stuck_mask=01.
- Priority: on the same cycle, core0 is stuck and core1 has exit=0x2 -> result=2 (ABORT). With max_cycles=50, TIMEOUT fires at cycle 51 when no other condition holds.
- Perf clean: CLEAN_CYCLES=3; perf_clean_req at cycle 5 and again at cycle 6 -> perf_clean high in cycles 6-8 only. Reset at cycle 7 -> perf_clean 0 at cycle 8.
- Instruction limit (macro on): max_instrs=1000, core1 steps 8 per cycle from cycle 0 -> DONE on the edge after instr_count[1] reaches 1000.
